// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction fetch queue entry layout and depth.
package cpu_defs_pkg;

    localparam int IFQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-width instruction queue between the I-cache and dual-issue decode.
// Accepts up to two words per cycle, presents head and head+1 to decode.
module inst_fetch_queue
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH  = IFQ_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en1,
    input  logic              wr_en2,
    input  logic [DATA_W-1:0] wr_inst1,
    input  logic [DATA_W-1:0] wr_inst2,
    input  logic [DATA_W-1:0] wr_pc1,
    input  logic              rd_en1,
    input  logic              rd_en2,
    output logic              rd_valid1,
    output logic              rd_valid2,
    output logic [DATA_W-1:0] rd_inst1,
    output logic [DATA_W-1:0] rd_inst2,
    output logic [DATA_W-1:0] rd_pc1,
    output logic [DATA_W-1:0] rd_pc2,
    output logic              queue_full,
    output logic              queue_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ifq_entry_t    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          rd_ok1;
    logic          rd_ok2;
    logic [1:0]    n_rd;
    logic [CW-1:0] free_slots;
    logic          wr_ok0;
    logic          wr_ok1;
    logic [1:0]    n_wr;
    ifq_entry_t    entry0;
    ifq_entry_t    entry1;

    // DEPTH is a power of two, so natural overflow of the pointer gives mod DEPTH
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr, input logic [PW-1:0] k);
        return ptr + k;
    endfunction

    // Reads use the pre-edge count; freed slots are reusable by same-cycle writes
    always_comb begin
        rd_ok1     = rd_en1 && (count != '0);
        rd_ok2     = rd_en1 && rd_en2 && (count >= CW'(2));
        n_rd       = {1'b0, rd_ok1} + {1'b0, rd_ok2};
        free_slots = CW'(DEPTH) - count + CW'(n_rd);
        wr_ok0     = (wr_en1 || wr_en2) && (free_slots != '0);
        wr_ok1     = wr_en1 && wr_en2 && (free_slots >= CW'(2));
        n_wr       = {1'b0, wr_ok0} + {1'b0, wr_ok1};
        entry1     = '{pc: wr_pc1 + DATA_W'(4), inst: wr_inst2};
        entry0     = wr_en1 ? '{pc: wr_pc1, inst: wr_inst1} : entry1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_ok0) begin
                mem[tail] <= entry0;
            end
            if (wr_ok1) begin
                mem[ptr_inc(tail, PW'(1))] <= entry1;
            end
            head  <= ptr_inc(head, PW'(n_rd));
            tail  <= ptr_inc(tail, PW'(n_wr));
            count <= count + CW'(n_wr) - CW'(n_rd);
        end
    end

    always_comb begin
        rd_valid1   = (count >= CW'(1));
        rd_valid2   = (count >= CW'(2));
        rd_inst1    = mem[head].inst;
        rd_pc1      = mem[head].pc;
        rd_inst2    = mem[ptr_inc(head, PW'(1))].inst;
        rd_pc2      = mem[ptr_inc(head, PW'(1))].pc;
        queue_full  = (CW'(DEPTH) - count) < CW'(2);
        queue_empty = (count == '0);
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random
// traffic, compared against a queue-based model of the fetch queue.
module tb_inst_fetch_queue;
    import cpu_defs_pkg::*;

    localparam int DEPTH = IFQ_DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en1 = 1'b0;
    logic        wr_en2 = 1'b0;
    logic [31:0] wr_inst1 = '0;
    logic [31:0] wr_inst2 = '0;
    logic [31:0] wr_pc1 = '0;
    logic        rd_en1 = 1'b0;
    logic        rd_en2 = 1'b0;
    logic        rd_valid1;
    logic        rd_valid2;
    logic [31:0] rd_inst1;
    logic [31:0] rd_inst2;
    logic [31:0] rd_pc1;
    logic [31:0] rd_pc2;
    logic        queue_full;
    logic        queue_empty;

    int total = 0;
    int bad = 0;

    ifq_entry_t model_q[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en1     (wr_en1),
        .wr_en2     (wr_en2),
        .wr_inst1   (wr_inst1),
        .wr_inst2   (wr_inst2),
        .wr_pc1     (wr_pc1),
        .rd_en1     (rd_en1),
        .rd_en2     (rd_en2),
        .rd_valid1  (rd_valid1),
        .rd_valid2  (rd_valid2),
        .rd_inst1   (rd_inst1),
        .rd_inst2   (rd_inst2),
        .rd_pc1     (rd_pc1),
        .rd_pc2     (rd_pc2),
        .queue_full (queue_full),
        .queue_empty(queue_empty)
    );

    always #5 clk = ~clk;

    // Queue model: reads pop from the front, writes are kept in order up to the free space
    task automatic model_update(input logic f, input logic w1, input logic w2,
                                input logic [31:0] i1, input logic [31:0] i2,
                                input logic [31:0] p1, input logic r1, input logic r2);
        int sz;
        int nrd;
        int free;
        ifq_entry_t wants[$];
        if (f) begin
            model_q.delete();
            return;
        end
        sz  = model_q.size();
        nrd = 0;
        if (r1 && sz >= 1) nrd = 1;
        if (r1 && r2 && sz >= 2) nrd = 2;
        repeat (nrd) void'(model_q.pop_front());
        free = DEPTH - sz + nrd;
        if (w1) wants.push_back('{pc: p1, inst: i1});
        if (w2) wants.push_back('{pc: p1 + 32'd4, inst: i2});
        foreach (wants[k]) begin
            if (k < free) model_q.push_back(wants[k]);
        end
    endtask

    task automatic step(input logic f, input logic w1, input logic w2,
                        input logic [31:0] i1, input logic [31:0] i2,
                        input logic [31:0] p1, input logic r1, input logic r2);
        flush = f; wr_en1 = w1; wr_en2 = w2;
        wr_inst1 = i1; wr_inst2 = i2; wr_pc1 = p1;
        rd_en1 = r1; rd_en2 = r2;
        @(posedge clk);
        model_update(f, w1, w2, i1, i2, p1, r1, r2);
        #1;
        flush = 0; wr_en1 = 0; wr_en2 = 0; rd_en1 = 0; rd_en2 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        step(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        total++; if (queue_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", queue_empty); end
        total++; if (queue_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", queue_full); end
        total++; if ({rd_valid1, rd_valid2} !== 2'b00) begin bad++; $display("[TB] FAIL reset_valid: got %b%b want 00", rd_valid1, rd_valid2); end
        total++; if ({rd_inst1, rd_inst2, rd_pc1, rd_pc2} !== 128'h0) begin bad++; $display("[TB] FAIL reset_data: got %h %h %h %h want all zero", rd_inst1, rd_inst2, rd_pc1, rd_pc2); end
    endtask

    task automatic test_dual_write();
        step(0, 1, 1, 32'h24080001, 32'h24090002, 32'hBFC00000, 0, 0);
        total++; if ({rd_valid1, rd_valid2} !== 2'b11) begin bad++; $display("[TB] FAIL dual_valid: got %b%b want 11", rd_valid1, rd_valid2); end
        total++; if (rd_pc1 !== 32'hBFC00000 || rd_inst1 !== 32'h24080001) begin bad++; $display("[TB] FAIL dual_head: got pc=%h inst=%h want pc=bfc00000 inst=24080001", rd_pc1, rd_inst1); end
        total++; if (rd_pc2 !== 32'hBFC00004 || rd_inst2 !== 32'h24090002) begin bad++; $display("[TB] FAIL dual_head1: got pc=%h inst=%h want pc=bfc00004 inst=24090002", rd_pc2, rd_inst2); end
        total++; if (queue_empty !== 1'b0) begin bad++; $display("[TB] FAIL dual_empty: got %b want 0", queue_empty); end
    endtask

    task automatic test_fill();
        logic [31:0] first_inst;
        logic [31:0] first_pc;
        logic [31:0] a;
        logic [31:0] b;
        step(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        first_pc = 32'h8000_0000;
        first_inst = $urandom;
        for (int n = 0; n < 8; n++) begin
            a = (n == 0) ? first_inst : $urandom;
            b = $urandom;
            step(0, 1, 1, a, b, first_pc + 32'(n * 8), 0, 0);
            total++; if (queue_full !== (n >= 7)) begin bad++; $display("[TB] FAIL fill_full_%0d: got %b want %b", n, queue_full, (n >= 7)); end
        end
        step(0, 1, 1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h9000_0000, 0, 0);
        total++; if (queue_full !== 1'b1) begin bad++; $display("[TB] FAIL overflow_full: got %b want 1", queue_full); end
        total++; if (rd_inst1 !== first_inst || rd_pc1 !== first_pc) begin bad++; $display("[TB] FAIL overflow_head: got pc=%h inst=%h want pc=%h inst=%h", rd_pc1, rd_inst1, first_pc, first_inst); end
        for (int n = 0; n < 8; n++) step(0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
        total++; if (queue_empty !== 1'b1) begin bad++; $display("[TB] FAIL overflow_dropped: got empty=%b want 1 after 16 reads", queue_empty); end
    endtask

    task automatic test_read_write();
        step(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h11111111, 32'h0, 32'h0000_1000, 0, 0);
        step(0, 1, 1, 32'h22222222, 32'h33333333, 32'h0000_2000, 1, 1);
        total++; if ({rd_valid1, rd_valid2} !== 2'b11) begin bad++; $display("[TB] FAIL rw_count: got valid=%b%b want 11", rd_valid1, rd_valid2); end
        total++; if (rd_inst1 !== 32'h22222222 || rd_pc1 !== 32'h0000_2000) begin bad++; $display("[TB] FAIL rw_head: got pc=%h inst=%h want pc=00002000 inst=22222222", rd_pc1, rd_inst1); end
        total++; if (rd_inst2 !== 32'h33333333 || rd_pc2 !== 32'h0000_2004) begin bad++; $display("[TB] FAIL rw_head1: got pc=%h inst=%h want pc=00002004 inst=33333333", rd_pc2, rd_inst2); end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        for (int n = 0; n < 7; n++) step(0, 1, 1, $urandom, $urandom, 32'(n * 8), 0, 0);
        for (int n = 0; n < 7; n++) step(0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
        step(0, 1, 0, 32'hAAAA0000, 32'h0, 32'h0000_4000, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
        total++; if (queue_empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_pre_empty: got %b want 1", queue_empty); end
        step(0, 1, 1, 32'hBBBB1111, 32'hCCCC2222, 32'h0000_5000, 0, 0);
        total++; if (rd_inst1 !== 32'hBBBB1111 || rd_pc1 !== 32'h0000_5000) begin bad++; $display("[TB] FAIL wrap_slot_hi: got pc=%h inst=%h want pc=00005000 inst=bbbb1111", rd_pc1, rd_inst1); end
        total++; if (rd_inst2 !== 32'hCCCC2222 || rd_pc2 !== 32'h0000_5004) begin bad++; $display("[TB] FAIL wrap_slot_lo: got pc=%h inst=%h want pc=00005004 inst=cccc2222", rd_pc2, rd_inst2); end
        step(0, 0, 1, 32'h0, 32'hDDDD3333, 32'h0000_6000, 1, 1);
        total++; if (rd_valid1 !== 1'b1 || rd_valid2 !== 1'b0 || rd_inst1 !== 32'hDDDD3333 || rd_pc1 !== 32'h0000_6004) begin bad++; $display("[TB] FAIL wrap_slot2_only: got v=%b%b pc=%h inst=%h want v=10 pc=00006004 inst=dddd3333", rd_valid1, rd_valid2, rd_pc1, rd_inst1); end
    endtask

    task automatic test_flush();
        step(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 1, 32'h1, 32'h2, 32'h100, 0, 0);
        step(0, 1, 1, 32'h3, 32'h4, 32'h108, 0, 0);
        step(0, 1, 0, 32'h5, 32'h0, 32'h110, 0, 0);
        step(1, 1, 0, 32'hEEEEEEEE, 32'h0, 32'h200, 1, 0);
        total++; if (queue_empty !== 1'b1 || rd_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty: got empty=%b valid1=%b want 1/0", queue_empty, rd_valid1); end
        step(0, 1, 0, 32'h77777777, 32'h0, 32'h300, 0, 0);
        total++; if (rd_valid1 !== 1'b1 || rd_valid2 !== 1'b0 || rd_inst1 !== 32'h77777777 || rd_pc1 !== 32'h300) begin bad++; $display("[TB] FAIL flush_after: got v=%b%b pc=%h inst=%h want v=10 pc=00000300 inst=77777777", rd_valid1, rd_valid2, rd_pc1, rd_inst1); end
    endtask

    task automatic test_random();
        logic f, w1, w2, r1, r2;
        for (int n = 0; n < 400; n++) begin
            f  = ($urandom_range(0, 39) == 0);
            w1 = ($urandom_range(0, 3) != 0);
            w2 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 1) != 0);
            r2 = ($urandom_range(0, 2) != 0);
            step(f, w1, w2, $urandom, $urandom, {$urandom_range(0, 32'hFFFF), 2'b00}, r1, r2);
            total++; if (rd_valid1 !== (model_q.size() >= 1) || rd_valid2 !== (model_q.size() >= 2)) begin bad++; $display("[TB] FAIL rand_valid_%0d: got %b%b want size=%0d", n, rd_valid1, rd_valid2, model_q.size()); end
            total++; if (queue_full !== (DEPTH - model_q.size() < 2) || queue_empty !== (model_q.size() == 0)) begin bad++; $display("[TB] FAIL rand_flags_%0d: got full=%b empty=%b want size=%0d", n, queue_full, queue_empty, model_q.size()); end
            if (model_q.size() >= 1) begin
                total++; if (rd_inst1 !== model_q[0].inst || rd_pc1 !== model_q[0].pc) begin bad++; $display("[TB] FAIL rand_head_%0d: got pc=%h inst=%h want pc=%h inst=%h", n, rd_pc1, rd_inst1, model_q[0].pc, model_q[0].inst); end
            end
            if (model_q.size() >= 2) begin
                total++; if (rd_inst2 !== model_q[1].inst || rd_pc2 !== model_q[1].pc) begin bad++; $display("[TB] FAIL rand_head1_%0d: got pc=%h inst=%h want pc=%h inst=%h", n, rd_pc2, rd_inst2, model_q[1].pc, model_q[1].inst); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_fill();
        test_read_write();
        test_wrap();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
